// File: rtl/unidade_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : unidade_writeback
//  Description : Write-back unit. Buffers up to two results in order, picks
//                the write value, captures synchronous load data one cycle
//                after acceptance and drives the register-file write port.
//                Also flags read-after-write hazards on the read ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module unidade_writeback (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  in_rd,
   input  logic        in_regwrite,
   input  logic [1:0]  in_sel,
   input  logic [31:0] in_alu,
   input  logic [31:0] in_pc4,
   input  logic [31:0] in_imm,
   input  logic [31:0] mem_rdata,
   input  logic        pausa,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   output logic        hazard1,
   output logic        hazard2,
   output logic [4:0]  rd,
   output logic [31:0] writedataR,
   output logic        regiwrite,
   output logic [1:0]  pending
);

   localparam logic [1:0] SEL_ALU  = 2'b00;
   localparam logic [1:0] SEL_LOAD = 2'b01;
   localparam logic [1:0] SEL_PC4  = 2'b10;

   // Two-slot circular buffer; slot validity derives from pending and rptr.
   logic [4:0]  e_rd   [2];
   logic        e_we   [2];
   logic        e_ld   [2];
   logic        e_ok   [2];
   logic [31:0] e_data [2];

   logic        rptr;
   logic        wptr;
   logic        ld_pend;   // a load was accepted on the previous edge
   logic        ld_idx;    // slot that load landed in
   logic        do_push;
   logic        do_pop;
   logic        is_load;
   logic [31:0] sel_val;
   logic [31:0] head_val;
   logic        slot_v0;
   logic        slot_v1;

   assign in_ready = rst_n && (pending < 2'd2);
   assign do_push  = in_valid && in_ready;
   assign do_pop   = !pausa && (pending != 2'd0);
   assign is_load  = (in_sel == SEL_LOAD);

   // A load head that has not been captured yet is the one accepted on the
   // previous edge, so its data is on mem_rdata right now.
   assign head_val = (e_ld[rptr] && !e_ok[rptr]) ? mem_rdata : e_data[rptr];

   // Select the value stored for a non-load result.
   always_comb begin
      sel_val = in_imm;
      case (in_sel)
         SEL_ALU: sel_val = in_alu;
         SEL_PC4: sel_val = in_pc4;
         default: sel_val = in_imm;
      endcase
   end

   // Buffer, load capture and write-port issue.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending    <= 2'd0;
         rptr       <= 1'b0;
         wptr       <= 1'b0;
         ld_pend    <= 1'b0;
         ld_idx     <= 1'b0;
         regiwrite  <= 1'b0;
         rd         <= 5'd0;
         writedataR <= 32'd0;
      end else begin
         regiwrite <= 1'b0;
         ld_pend   <= 1'b0;
         // Capture is unconditional; if the slot was popped on this same
         // edge the write lands in a free slot and is harmless.
         if (ld_pend) begin
            e_data[ld_idx] <= mem_rdata;
            e_ok[ld_idx]   <= 1'b1;
         end
         if (do_push) begin
            e_rd[wptr]   <= in_rd;
            e_we[wptr]   <= in_regwrite && (in_rd != 5'd0);
            e_ld[wptr]   <= is_load;
            e_ok[wptr]   <= !is_load;
            e_data[wptr] <= sel_val;
            wptr         <= ~wptr;
            ld_pend      <= is_load;
            ld_idx       <= wptr;
         end
         if (do_pop) begin
            rd         <= e_rd[rptr];
            writedataR <= head_val;
            regiwrite  <= e_we[rptr];
            rptr       <= ~rptr;
         end
         pending <= pending + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   assign slot_v0 = (pending == 2'd2) || ((pending == 2'd1) && (rptr == 1'b0));
   assign slot_v1 = (pending == 2'd2) || ((pending == 2'd1) && (rptr == 1'b1));

   // Hazard on buffered writes, plus the write being committed this cycle
   // since the register file returns the old value on a same-edge read.
   always_comb begin
      hazard1 = (rs1 != 5'd0) &&
                ((slot_v0 && e_we[0] && (e_rd[0] == rs1)) ||
                 (slot_v1 && e_we[1] && (e_rd[1] == rs1)) ||
                 (regiwrite && (rd == rs1)));
      hazard2 = (rs2 != 5'd0) &&
                ((slot_v0 && e_we[0] && (e_rd[0] == rs2)) ||
                 (slot_v1 && e_we[1] && (e_rd[1] == rs2)) ||
                 (regiwrite && (rd == rs2)));
   end

endmodule
`default_nettype wire

// File: tb/tb_unidade_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : tb_unidade_writeback
//  Description : Self-checking bench for unidade_writeback. Expected writes
//                are queued when a result is offered and compared whenever
//                the write port pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_unidade_writeback;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_rd;
   logic        in_regwrite;
   logic [1:0]  in_sel;
   logic [31:0] in_alu;
   logic [31:0] in_pc4;
   logic [31:0] in_imm;
   logic [31:0] mem_rdata;
   logic        pausa;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic        hazard1;
   logic        hazard2;
   logic [4:0]  rd;
   logic [31:0] writedataR;
   logic        regiwrite;
   logic [1:0]  pending;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   unidade_writeback dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_rd      (in_rd),
      .in_regwrite(in_regwrite),
      .in_sel     (in_sel),
      .in_alu     (in_alu),
      .in_pc4     (in_pc4),
      .in_imm     (in_imm),
      .mem_rdata  (mem_rdata),
      .pausa      (pausa),
      .rs1        (rs1),
      .rs2        (rs2),
      .hazard1    (hazard1),
      .hazard2    (hazard2),
      .rd         (rd),
      .writedataR (writedataR),
      .regiwrite  (regiwrite),
      .pending    (pending)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one edge; load data is only valid for the cycle after accept.
   task automatic tick();
      @(posedge clk);
      #1;
      mem_rdata = $urandom;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Offer one result; for loads v is the data presented on mem_rdata.
   task automatic send(input logic [4:0] r, input logic w, input logic [1:0] s,
                       input logic [31:0] v, input bit push_exp);
      int n;
      in_valid    = 1'b1;
      in_rd       = r;
      in_regwrite = w;
      in_sel      = s;
      in_alu      = $urandom;
      in_pc4      = $urandom;
      in_imm      = $urandom;
      case (s)
         2'b00:   in_alu = v;
         2'b10:   in_pc4 = v;
         2'b11:   in_imm = v;
         default: ;
      endcase
      n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      if (n == 50) check("ready_timeout", {31'd0, in_ready}, 32'd1);
      if (push_exp) sb.push_back('{rd: r, data: v});
      tick();
      in_valid = 1'b0;
      if (s == 2'b01) mem_rdata = v;
   endtask

   // Scoreboard: every write-port pulse must match the oldest expected write.
   always @(negedge clk) begin
      if (regiwrite) begin
         check("write_expected", {31'd0, sb.size() != 0}, 32'd1);
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("wr_rd", {27'd0, rd}, {27'd0, e.rd});
            check("wr_data", writedataR, e.data);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_rd = 5'd0; in_regwrite = 1'b0;
      in_sel = 2'b00; in_alu = 32'd0; in_pc4 = 32'd0; in_imm = 32'd0;
      mem_rdata = 32'd0; pausa = 1'b0; rs1 = 5'd0; rs2 = 5'd0;

      // Reset state
      idle(3);
      check("rst_regiwrite", {31'd0, regiwrite}, 32'd0);
      check("rst_rd", {27'd0, rd}, 32'd0);
      check("rst_wdata", writedataR, 32'd0);
      check("rst_pending", {30'd0, pending}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_hazards", {30'd0, hazard1, hazard2}, 32'd0);
      rst_n = 1'b1;
      #1;
      check("ready_after_rst", {31'd0, in_ready}, 32'd1);

      // ALU result, one-cycle latency, single pulse
      send(5'd5, 1'b1, 2'b00, 32'h0000_00AA, 1'b1);
      check("alu_pending1", {30'd0, pending}, 32'd1);
      check("alu_no_early_wr", {31'd0, regiwrite}, 32'd0);
      tick();
      check("alu_we", {31'd0, regiwrite}, 32'd1);
      check("alu_rd", {27'd0, rd}, 32'd5);
      check("alu_data", writedataR, 32'h0000_00AA);
      check("alu_pending0", {30'd0, pending}, 32'd0);
      tick();
      check("alu_pulse_end", {31'd0, regiwrite}, 32'd0);

      // Load popped immediately uses mem_rdata directly
      send(5'd7, 1'b1, 2'b01, 32'hDEAD_BEEF, 1'b1);
      tick();
      check("ld_we", {31'd0, regiwrite}, 32'd1);
      check("ld_rd", {27'd0, rd}, 32'd7);
      check("ld_data", writedataR, 32'hDEAD_BEEF);

      // Load held by pausa is issued later from the captured value
      pausa = 1'b1;
      send(5'd7, 1'b1, 2'b01, 32'hCAFE_F00D, 1'b1);
      idle(3);
      check("ldp_held", {31'd0, regiwrite}, 32'd0);
      check("ldp_pending", {30'd0, pending}, 32'd1);
      pausa = 1'b0;
      tick();
      check("ldp_we", {31'd0, regiwrite}, 32'd1);
      check("ldp_data", writedataR, 32'hCAFE_F00D);
      tick();

      // Full buffer: ready drops after two accepts, order preserved
      pausa = 1'b1;
      send(5'd10, 1'b1, 2'b10, 32'h0000_1000, 1'b1);
      send(5'd11, 1'b1, 2'b11, 32'h0000_2000, 1'b1);
      check("full_ready", {31'd0, in_ready}, 32'd0);
      check("full_pending", {30'd0, pending}, 32'd2);
      tick();
      check("full_hold", {30'd0, pending}, 32'd2);
      pausa = 1'b0;
      send(5'd12, 1'b1, 2'b00, 32'h0000_3000, 1'b1);
      check("order_2nd_rd", {27'd0, rd}, 32'd11);
      check("order_2nd_we", {31'd0, regiwrite}, 32'd1);
      tick();
      check("order_3rd_rd", {27'd0, rd}, 32'd12);
      check("order_3rd_we", {31'd0, regiwrite}, 32'd1);
      tick();

      // Write to x0 is issued with the enable suppressed
      send(5'd0, 1'b1, 2'b00, 32'h0000_0055, 1'b0);
      check("x0_hazard_buf", {31'd0, hazard1}, 32'd0);
      tick();
      check("x0_we", {31'd0, regiwrite}, 32'd0);
      check("x0_data", writedataR, 32'h0000_0055);
      check("x0_hazard", {31'd0, hazard1}, 32'd0);
      check("x0_pending", {30'd0, pending}, 32'd0);

      // Hazards on buffered write and during the commit cycle
      pausa = 1'b1;
      rs1 = 5'd3;
      rs2 = 5'd4;
      send(5'd3, 1'b1, 2'b00, 32'h0000_0033, 1'b1);
      check("hz1_buf", {31'd0, hazard1}, 32'd1);
      check("hz2_buf", {31'd0, hazard2}, 32'd0);
      pausa = 1'b0;
      tick();
      check("hz1_commit", {31'd0, hazard1}, 32'd1);
      tick();
      check("hz1_clear", {31'd0, hazard1}, 32'd0);
      rs1 = 5'd0;
      rs2 = 5'd0;

      // Back-to-back mixed results, one write per cycle
      send(5'd20, 1'b1, 2'b11, 32'h1111_1111, 1'b1);
      send(5'd21, 1'b1, 2'b01, 32'h2222_2222, 1'b1);
      send(5'd22, 1'b1, 2'b10, 32'h3333_3333, 1'b1);
      send(5'd23, 1'b0, 2'b00, 32'h4444_4444, 1'b0);
      idle(3);
      check("b2b_drained", {30'd0, pending}, 32'd0);

      // Reset right after a load: nothing issues, load data ignored
      send(5'd9, 1'b1, 2'b01, 32'h0000_1234, 1'b0);
      rst_n = 1'b0;
      tick();
      check("rl_pending", {30'd0, pending}, 32'd0);
      check("rl_we", {31'd0, regiwrite}, 32'd0);
      check("rl_rd", {27'd0, rd}, 32'd0);
      check("rl_data", writedataR, 32'd0);
      check("rl_ready", {31'd0, in_ready}, 32'd0);
      rst_n = 1'b1;
      idle(3);
      check("rl_pending_after", {30'd0, pending}, 32'd0);
      check("rl_data_after", writedataR, 32'd0);

      check("sb_empty", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/unidade_writeback.md
# unidade_writeback

Write-back unit that drives the write port of the 32×32 register file (`rd`, `writedataR`, `regiwrite`) from results leaving the execute/memory stage. It accepts results through a valid/ready handshake and selects the write value. It buffers up to two pending writes in order and captures synchronous-memory load data one cycle after acceptance. It also reports read-after-write hazards for the register file's registered read ports.

## Interface
Parameters: none; data width is fixed at 32 and register address width at 5.

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  synchronous reset, active-low
- `in_valid`  in  1  result offered
- `in_ready`  out  1  unit can accept; transfer occurs on an edge with `in_valid && in_ready`
- `in_rd`  in  5  destination register
- `in_regwrite`  in  1  result writes a register
- `in_sel`  in  2  source select: 00 ALU, 01 load (mem_rdata), 10 PC+4, 11 immediate
- `in_alu`, `in_pc4`, `in_imm`  in  32 each  candidate write values
- `mem_rdata`  in  32  load data, valid exactly in the cycle after a load is accepted
- `pausa`  in  1  inhibits write-port issue (pop) while high
- `rs1`, `rs2`  in  5 each  addresses being presented to the register file read ports
- `hazard1`, `hazard2`  out  1 each  pending write to `rs1` / `rs2`
- `rd`  out  5  register-file write address
- `writedataR`  out  32  register-file write data
- `regiwrite`  out  1  register-file write enable
- `pending`  out  2  number of buffered entries (0–2)

## Operation
- Buffer: 2-entry in-order FIFO. Each entry holds {rd, we, is_load, data_ok, data}.
- Push on accept: `we = in_regwrite && in_rd != 0`. Writes to x0 are suppressed here because the register file does not hardwire x0.
  - Non-load entries store the selected value with `data_ok = 1`.
  - Load entries are pushed with `data_ok = 0`.
- Load capture: at the edge following acceptance of a load, that entry's data is set to `mem_rdata` and `data_ok` to 1. This happens unconditionally, regardless of `pausa` and whether or not the entry is the head.
- Pop: on an edge with `!pausa && pending > 0`, the head is issued:
  - `rd <= head.rd`
  - `writedataR <= head.data`, or `mem_rdata` if the head is a load with `data_ok = 0`
  - `regiwrite <= head.we`
- Without a pop, `regiwrite <= 0` and `rd`/`writedataR` hold. `regiwrite` is a one-cycle pulse per issued entry.
- `in_ready = rst_n && pending < 2`. A push while full cannot occur. A push and a pop on the same edge keep `pending` unchanged. `pending` never wraps.
- Hazards (combinational):
  - `hazardN = 1` if `rsN != 0` and `rsN` matches `rd` of any FIFO entry with `we = 1`, or if `regiwrite = 1 && rd == rsN`.
  - The second term exists because the register file samples reads on the same edge it writes, so it returns the old value.
  - Incoming (`in_*`) values are not considered.
- Reset (`rst_n` low at an edge): FIFO emptied, `pending = 0`, `regiwrite = 0`, `rd = 0`, `writedataR = 0`. Any in-flight load is discarded and `mem_rdata` in the following cycle is ignored.

## Timing
- Accept at edge E0; pop at earliest E1. `regiwrite` is high during cycle E1→E2, and the register file commits at E2.
- This minimum latency is identical for ALU, PC+4, immediate and load results.
- A load accepted at E0 and popped at E1 uses `mem_rdata` directly; if not popped at E1, it is captured at E1.
- With `pausa` held for k cycles, issue is delayed by k cycles and order is preserved.
- Sustained throughput is 1 write per cycle with `pausa` low.
- The two-entry buffer means `in_ready` drops only after two accepts without pops.
- While `rst_n` is low, all outputs except `hazard1`/`hazard2` hold their reset values and `in_ready = 0`. With an empty FIFO and `regiwrite = 0`, both hazards are 0.

## Test plan
- Reset, then accept ALU result rd=5, data 0x0000_00AA, `pausa` = 0 → `regiwrite` = 1, `rd` = 5, `writedataR` = 0xAA for exactly one cycle, one cycle after accept; `pending` returns to 0.
- Accept load rd=7, then drive `mem_rdata` = 0xDEAD_BEEF next cycle only → write rd=7, data 0xDEADBEEF. Repeat with `pausa` high for 3 cycles → same data is issued later from the captured value.
- Hold `pausa` = 1 and offer three results → `in_ready` = 0 after two accepts and `pending` = 2. Release `pausa` → writes issue in original order on consecutive cycles.
- Accept result rd=0 with `in_regwrite` = 1 → entry is issued with `regiwrite` = 0. `hazard1` = 0 for `rs1` = 0 throughout.
- Buffer rd=3 (`pausa` = 1) with `rs1` = 3, `rs2` = 4 → `hazard1` = 1, `hazard2` = 0. Release → `hazard1` stays 1 during the `regiwrite` cycle, then drops to 0.
- Accept a load, then assert reset on the next edge with `mem_rdata` = 0x1234 → no write ever issues, `pending` = 0, and all outputs are at reset values.
